cpu_sequencer: RTL and testbench

Fetch/execute control unit for the small-lang accumulator CPU. It walks the program counter, fetches the opcode word and optional argument word from the single synchronous program/data memory, and presents the latched opcode to `inst_decoder` with a one-cycle `enable` strobe. It resolves `jmp`/`jmz`, halts on `hlt` and flags unimplemented opcodes. It sits between the memory port and the decoder/accumulator datapath at CPU top level.

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/cpu_sequencer.sv | 124 ++++++++++++
 tb/tb_cpu_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode-class helpers
// for the small-lang accumulator CPU (used by cpu_sequencer and inst_decoder).
package cpu_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t OP_HLT   = 16'h0000;
  localparam word_t OP_ARG   = 16'h0001;
  localparam word_t OP_SHR   = 16'h0002;
  localparam word_t OP_SHL   = 16'h0003;
  localparam word_t OP_NAD   = 16'h0004;
  localparam word_t OP_JMP   = 16'h0005;
  localparam word_t OP_JMZ   = 16'h0006;
  localparam word_t OP_RES7  = 16'h0007;
  localparam word_t OP_RES8  = 16'h0008;
  localparam word_t OP_READ  = 16'h0009;
  localparam word_t OP_WRITE = 16'h000A;
  localparam word_t OP_RESB  = 16'h000B;
  localparam word_t OP_RESC  = 16'h000C;
  localparam word_t OP_OUT   = 16'h000D;
  localparam word_t OP_RESE  = 16'h000E;
  localparam word_t OP_RES   = 16'h000F;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_INST  = 3'd1,
    ST_ARG   = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Opcode is followed by an argument word.
  function automatic logic has_arg(input word_t op);
    return (op == OP_ARG) || (op == OP_JMP) || (op == OP_JMZ) ||
           (op == OP_READ) || (op == OP_WRITE) || (op == OP_OUT);
  endfunction

  // Opcode needs the word at address `arg` valid during EXEC.
  function automatic logic is_mem_read(input word_t op);
    return (op == OP_READ) || (op == OP_OUT);
  endfunction

  function automatic logic is_illegal(input word_t op);
    return (op > OP_RES) ||
           (op inside {OP_RES7, OP_RES8, OP_RESB, OP_RESC, OP_RESE, OP_RES});
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: walks the pc, fetches opcode and argument words,
// strobes the decoder for one EXEC cycle, resolves jumps and halts.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter bit          START_HALTED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic        acc_zero,
  input  logic        resume,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [15:0] inst,
  output logic [15:0] arg,
  output logic        dec_enable,
  output logic [15:0] pc,
  output logic        halted,
  output logic        illegal
);

  state_t state;
  word_t  next_pc;

  // Next-pc mux, consumed only in EXEC.
  always_comb begin
    next_pc = pc + 16'd1;
    if (inst == OP_JMP) begin
      next_pc = arg;
    end else if (inst == OP_JMZ) begin
      next_pc = acc_zero ? arg : pc + 16'd2;
    end else if (has_arg(inst)) begin
      next_pc = pc + 16'd2;
    end
  end

  // Memory port must react to the opcode word in the same cycle it arrives,
  // so the address/read strobe are decoded from state and mem_rdata here.
  always_comb begin
    mem_addr = rst_n ? arg : 16'h0000;
    mem_rd   = 1'b0;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          mem_addr = pc;
          mem_rd   = 1'b1;
        end
        ST_INST: begin
          if (has_arg(mem_rdata)) begin
            mem_addr = pc + 16'd1;
            mem_rd   = 1'b1;
          end
        end
        ST_ARG: begin
          if (is_mem_read(inst)) begin
            mem_addr = mem_rdata;
            mem_rd   = 1'b1;
          end
        end
        default: begin
          mem_rd = 1'b0;
        end
      endcase
    end
  end

  // Sequencer FSM; dec_enable/illegal/halted are registered with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= START_HALTED ? ST_HALT : ST_FETCH;
      pc         <= RESET_PC;
      inst       <= 16'h0000;
      arg        <= 16'h0000;
      dec_enable <= 1'b0;
      illegal    <= 1'b0;
      halted     <= START_HALTED;
    end else begin
      dec_enable <= 1'b0;
      illegal    <= 1'b0;
      case (state)
        ST_FETCH: begin
          state <= ST_INST;
        end
        ST_INST: begin
          inst <= mem_rdata;
          if (has_arg(mem_rdata)) begin
            state <= ST_ARG;
          end else begin
            state      <= ST_EXEC;
            dec_enable <= 1'b1;
            illegal    <= is_illegal(mem_rdata);
          end
        end
        ST_ARG: begin
          arg        <= mem_rdata;
          state      <= ST_EXEC;
          dec_enable <= 1'b1;
        end
        ST_EXEC: begin
          pc <= next_pc;
          if (inst == OP_HLT) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (resume) begin
            state  <= ST_FETCH;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= ST_FETCH;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed programs in a shared memory
// model, EXEC-cycle monitor compares against queued expectations.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, acc_zero, resume;
  logic [15:0] mem_rdata, mem_addr, inst, arg, pc;
  logic        mem_rd, dec_enable, halted, illegal;

  logic        rst_n_h, acc_zero_h, resume_h;
  logic [15:0] mem_rdata_h, mem_addr_h, inst_h, arg_h, pc_h;
  logic        mem_rd_h, dec_enable_h, halted_h, illegal_h;

  logic [15:0] mem [65536];

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] arg;
    logic [15:0] pc;
    logic        ill;
    logic        chk_rd;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   dec_h_cnt = 0;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .acc_zero(acc_zero),
    .resume(resume), .mem_addr(mem_addr), .mem_rd(mem_rd), .inst(inst),
    .arg(arg), .dec_enable(dec_enable), .pc(pc), .halted(halted),
    .illegal(illegal)
  );

  cpu_sequencer #(.RESET_PC(16'h0100), .START_HALTED(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n_h), .mem_rdata(mem_rdata_h), .acc_zero(acc_zero_h),
    .resume(resume_h), .mem_addr(mem_addr_h), .mem_rd(mem_rd_h), .inst(inst_h),
    .arg(arg_h), .dec_enable(dec_enable_h), .pc(pc_h), .halted(halted_h),
    .illegal(illegal_h)
  );

  // Synchronous memory: data valid the cycle after the read request.
  always @(posedge clk) begin
    if (mem_rd)   mem_rdata   <= mem[mem_addr];
    if (mem_rd_h) mem_rdata_h <= mem[mem_addr_h];
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] i, input logic [15:0] a, input logic [15:0] p,
                      input logic il, input logic cr = 1'b0, input logic [15:0] rd = 16'h0000);
    sb.push_back('{inst: i, arg: a, pc: p, ill: il, chk_rd: cr, rdata: rd});
  endtask

  // Monitor: every EXEC cycle of the main DUT consumes one expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dec_enable === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_exec_pc", pc, 16'hxxxx);
      end else begin
        mon_e = sb.pop_front();
        chk("exec_inst", inst, mon_e.inst);
        chk("exec_arg", arg, mon_e.arg);
        chk("exec_pc", pc, mon_e.pc);
        chk("exec_illegal", 16'(illegal), 16'(mon_e.ill));
        if (mon_e.chk_rd) chk("exec_rdata", mem_rdata, mon_e.rdata);
      end
    end
    if (rst_n === 1'b1 && illegal === 1'b1 && dec_enable !== 1'b1)
      chk("illegal_outside_exec", 16'(illegal), 16'h0000);
    if (dec_enable_h === 1'b1) dec_h_cnt++;
  end

  task automatic do_reset();
    rst_n  = 1'b0;
    resume = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_exec(input logic [15:0] op, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (dec_enable === 1'b1 && inst === op) found = 1'b1;
    end
    chk("wait_exec_found", 16'(found), 16'h0001);
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && halted !== 1'b1; i++) @(negedge clk);
    chk("halt_reached", 16'(halted), 16'h0001);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] de_hist, hl_hist;
    rst_n = 1'b0; acc_zero = 1'b0; resume = 1'b0;
    rst_n_h = 1'b0; acc_zero_h = 1'b0; resume_h = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;

    // Program "arg 5; hlt" with cycle-exact strobe/halt timing and reset state.
    mem[0] = 16'h0001; mem[1] = 16'h0005; mem[2] = 16'h0000;
    push(16'h0001, 16'h0005, 16'h0000, 1'b0);
    push(16'h0000, 16'h0005, 16'h0002, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_arg", arg, 16'h0000);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_rd", 16'(mem_rd), 16'h0000);
    chk("rst_dec_enable", 16'(dec_enable), 16'h0000);
    chk("rst_illegal", 16'(illegal), 16'h0000);
    chk("rst_halted", 16'(halted), 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      de_hist[k-1] = dec_enable;
      hl_hist[k-1] = halted;
      if (k == 4) chk("t1_arg_in_exec", arg, 16'h0005);
      if (k == 8) chk("t1_pc_at_halt", pc, 16'h0003);
    end
    chk("t1_dec_enable_cycles", 16'(de_hist), 16'h0048);
    chk("t1_halted_cycles", 16'(hl_hist), 16'h0180);

    // jmp 0x10; jmz 0x40 taken, then not taken.
    mem[0] = 16'h0005; mem[1] = 16'h0010;
    mem[16'h0010] = 16'h0006; mem[16'h0011] = 16'h0040;
    mem[16'h0012] = 16'h0000; mem[16'h0040] = 16'h0000;
    acc_zero = 1'b1;
    push(16'h0005, 16'h0010, 16'h0000, 1'b0);
    push(16'h0006, 16'h0040, 16'h0010, 1'b0);
    push(16'h0000, 16'h0040, 16'h0040, 1'b0);
    do_reset();
    wait_exec(16'h0006, 20);
    @(negedge clk);
    chk("jmz_taken_fetch_rd", 16'(mem_rd), 16'h0001);
    chk("jmz_taken_fetch_addr", mem_addr, 16'h0040);
    wait_halt(20);
    acc_zero = 1'b0;
    push(16'h0005, 16'h0010, 16'h0000, 1'b0);
    push(16'h0006, 16'h0040, 16'h0010, 1'b0);
    push(16'h0000, 16'h0040, 16'h0012, 1'b0);
    do_reset();
    wait_exec(16'h0006, 20);
    @(negedge clk);
    chk("jmz_fall_fetch_addr", mem_addr, 16'h0012);
    wait_halt(20);

    // read 0x0200 with operand in EXEC; resume outside HALT is ignored.
    mem[0] = 16'h0009; mem[1] = 16'h0200; mem[2] = 16'h0000;
    mem[16'h0200] = 16'hBEEF;
    push(16'h0009, 16'h0200, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
    push(16'h0000, 16'h0200, 16'h0002, 1'b0);
    do_reset();
    resume = 1'b1;
    @(negedge clk);
    chk("read_fetch_addr", mem_addr, 16'h0000);
    @(negedge clk);
    chk("read_inst_addr", mem_addr, 16'h0001);
    chk("read_inst_rd", 16'(mem_rd), 16'h0001);
    @(negedge clk);
    chk("read_arg_addr", mem_addr, 16'h0200);
    chk("read_arg_rd", 16'(mem_rd), 16'h0001);
    resume = 1'b0;
    wait_halt(20);

    // Two illegal opcodes run as NOPs, then resume out of HALT.
    mem[0] = 16'h0007; mem[1] = 16'h1234; mem[2] = 16'h0000;
    mem[3] = 16'h0002; mem[4] = 16'h0000;
    push(16'h0007, 16'h0000, 16'h0000, 1'b1);
    push(16'h1234, 16'h0000, 16'h0001, 1'b1);
    push(16'h0000, 16'h0000, 16'h0002, 1'b0);
    do_reset();
    wait_halt(30);
    chk("illegal_pc_after", pc, 16'h0003);
    push(16'h0002, 16'h0000, 16'h0003, 1'b0);
    push(16'h0000, 16'h0000, 16'h0004, 1'b0);
    @(posedge clk); #1 resume = 1'b1;
    @(posedge clk); #1 resume = 1'b0;
    wait_halt(30);
    chk("resume_pc_after", pc, 16'h0005);

    // Argument op at 0xFFFF wraps its argument fetch to 0x0000.
    mem[0] = 16'h0005; mem[1] = 16'hFFFF; mem[2] = 16'h0000;
    mem[16'hFFFF] = 16'h0001;
    push(16'h0005, 16'hFFFF, 16'h0000, 1'b0);
    push(16'h0001, 16'h0005, 16'hFFFF, 1'b0);
    push(16'hFFFF, 16'h0005, 16'h0001, 1'b1);
    push(16'h0000, 16'h0005, 16'h0002, 1'b0);
    do_reset();
    wait_exec(16'h0005, 20);
    @(negedge clk);
    chk("wrap_fetch_addr", mem_addr, 16'hFFFF);
    @(negedge clk);
    chk("wrap_arg_addr", mem_addr, 16'h0000);
    chk("wrap_arg_rd", 16'(mem_rd), 16'h0001);
    wait_halt(30);
    chk("wrap_pc_after", pc, 16'h0003);

    // START_HALTED instance: reset beats resume, holds in HALT, abort in ARG.
    mem[16'h0100] = 16'h000A; mem[16'h0101] = 16'h0300; mem[16'h0102] = 16'h0000;
    @(posedge clk); #1 resume_h = 1'b1;
    @(negedge clk);
    chk("h_rst_halted", 16'(halted_h), 16'h0001);
    chk("h_rst_pc", pc_h, 16'h0100);
    @(posedge clk); #1 rst_n_h = 1'b1; resume_h = 1'b0;
    repeat (5) @(negedge clk);
    chk("h_stays_halted", 16'(halted_h), 16'h0001);
    chk("h_no_exec_while_halted", 16'(dec_h_cnt), 16'h0000);
    @(posedge clk); #1 resume_h = 1'b1;
    @(posedge clk); #1 resume_h = 1'b0;
    @(negedge clk);
    chk("h_fetch_addr", mem_addr_h, 16'h0100);
    @(negedge clk);
    chk("h_inst_addr", mem_addr_h, 16'h0101);
    @(posedge clk); #1 rst_n_h = 1'b0;
    @(posedge clk); #1;
    chk("h_abort_halted", 16'(halted_h), 16'h0001);
    chk("h_abort_pc", pc_h, 16'h0100);
    chk("h_abort_inst", inst_h, 16'h0000);
    chk("h_abort_arg", arg_h, 16'h0000);
    chk("h_abort_no_exec", 16'(dec_h_cnt), 16'h0000);
    rst_n_h = 1'b1;
    @(posedge clk); #1 resume_h = 1'b1;
    @(posedge clk); #1 resume_h = 1'b0;
    for (int i = 0; i < 30 && halted_h !== 1'b1; i++) @(negedge clk);
    chk("h_halt_reached", 16'(halted_h), 16'h0001);
    chk("h_exec_count", 16'(dec_h_cnt), 16'h0002);
    chk("h_pc_after", pc_h, 16'h0103);
    chk("h_arg_after", arg_h, 16'h0300);

    chk("scoreboard_drained", 16'(sb.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
